// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan path: segment width,
// hex glyph table and scan FSM state encoding.
package seg7_pkg;

    localparam int SEG7_W = 8;

    // Segment patterns {g,f,e,d,c,b,a} for hex codes 0..F.
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        S_LOAD,
        S_GUARD,
        S_ON
    } seg7_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment lookup ({g..a}, active-high).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG7_HEX[code];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for an N-digit seven-segment display with a
// per-frame input snapshot and a blanked guard window at the start of each slot.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     seg7_sel,
    output logic [SEG7_W-1:0]     seg7,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    seg7_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             load;

    logic [DIGITS-1:0][3:0] dig_sh;
    logic [DIGITS-1:0]      dp_sh;
    logic [DIGITS-1:0]      blank_sh;
    logic [DIGITS-1:0]      blank_load;

    logic [6:0]             hex_seg;
    logic [DIGITS-1:0]      sel_n;
    logic [SEG7_W-1:0]      seg_n;

`ifdef SEG7_LZB_EN
    // A digit is auto-blanked when it and every digit above it read as
    // code 0 with no decimal point; digit 0 always stays visible.
    logic [DIGITS-1:0] lz;
    logic              seen;

    always_comb begin
        lz   = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digits[4*i +: 4] != 4'h0 || dp[i]) seen = 1'b1;
            lz[i] = !seen;
        end
    end

    assign blank_load = blank | lz;
`else
    assign blank_load = blank;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        load    = 1'b0;
        case (state)
            S_LOAD: begin
                // The load cycle doubles as slot cycle 0 of digit 0.
                load    = 1'b1;
                idx_n   = '0;
                cnt_n   = CNT_W'(1);
                state_n = (GUARD == 1) ? S_ON : S_GUARD;
            end
            S_GUARD: begin
                if (cnt == GUARD_LAST) state_n = S_ON;
            end
            S_ON: begin
                if (cnt == SLOT_LAST) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = S_LOAD;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = S_GUARD;
                    end
                end
            end
            default: begin
                state_n = S_LOAD;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    seg7_hex_decode u_dec (
        .code (dig_sh[idx]),
        .seg  (hex_seg)
    );

    always_comb begin
        sel_n = '0;
        seg_n = '0;
        if (state == S_ON) begin
            sel_n = DIGITS'(1) << idx;
            if (!blank_sh[idx]) seg_n = {dp_sh[idx], hex_seg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            cnt         <= '0;
            idx         <= '0;
            dig_sh      <= '0;
            dp_sh       <= '0;
            blank_sh    <= '0;
            seg7_sel    <= '0;
            seg7        <= '0;
            frame_start <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (load) begin
                dig_sh   <= digits;
                dp_sh    <= dp;
                blank_sh <= blank_load;
            end
            seg7_sel    <= sel_n;
            seg7        <= seg_n;
            frame_start <= load;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIGITS=8, SCAN_DIV=8, GUARD=2.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  seg7_sel;
    logic [7:0]  seg7;
    logic        frame_start;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] exp_dig [8];

    seg7_scan #(
        .DIGITS   (8),
        .SCAN_DIV (8),
        .GUARD    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .seg7_sel    (seg7_sel),
        .seg7        (seg7),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_start !== 1'b1 && t < 200);
        chk("wait_frame_start", {31'd0, frame_start}, 32'd1);
    endtask

    // Called at the negedge where frame_start is high; checks one full frame
    // and the start of the next. Optionally changes digits at cycle chg_k.
    task automatic check_frame(input string name, input int chg_k, input logic [31:0] chg_val);
        logic [7:0] e_sel, e_seg;
        for (int k = 0; k < 64; k++) begin
            if (k % 8 < 2) begin
                e_sel = 8'h00;
                e_seg = 8'h00;
            end else begin
                e_sel = 8'h01 << (k / 8);
                e_seg = exp_dig[k / 8];
            end
            chk($sformatf("%s k%0d frame_start", name, k), {31'd0, frame_start}, (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s k%0d seg7_sel", name, k), {24'd0, seg7_sel}, {24'd0, e_sel});
            chk($sformatf("%s k%0d seg7", name, k), {24'd0, seg7}, {24'd0, e_seg});
            chk($sformatf("%s k%0d onehot", name, k), ($countones(seg7_sel) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (k == chg_k) digits = chg_val;
            @(negedge clk);
        end
        chk({name, " next_frame_start"}, {31'd0, frame_start}, 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        digits = 32'h0;
        dp     = 8'h00;
        blank  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset seg7_sel", {24'd0, seg7_sel}, 32'h0);
        chk("reset seg7", {24'd0, seg7}, 32'h0);
        chk("reset frame_start", {31'd0, frame_start}, 32'h0);

        // Basic scan of 7654_3210.
        digits = 32'h7654_3210;
        rst    = 1'b0;
        @(negedge clk);
        chk("first frame_start", {31'd0, frame_start}, 32'd1);
        exp_dig = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
        check_frame("basic", -1, 32'h0);

        // Upper hex codes, dp on digit 7 only; takes effect next frame.
        digits = 32'hFEDC_BA98;
        dp     = 8'h80;
        wait_fs();
        exp_dig = '{8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'hF1};
        check_frame("hex_hi", -1, 32'h0);

        // Snapshot: change during digit 3 on-time is invisible this frame.
        digits = 32'h1111_1111;
        dp     = 8'h00;
        wait_fs();
        exp_dig = '{8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06};
        check_frame("snap_old", 28, 32'h2222_2222);
        exp_dig = '{8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B};
        check_frame("snap_new", -1, 32'h0);

        // Explicit blanking of the low nibble with every dp lit.
        digits = 32'h7654_3210;
        dp     = 8'hFF;
        blank  = 8'h0F;
        wait_fs();
        exp_dig = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE6, 8'hED, 8'hFD, 8'h87};
        check_frame("blank", -1, 32'h0);

        // Reset mid-slot of digit 5.
        repeat (44) @(negedge clk);
        chk("pre_rst seg7_sel", {24'd0, seg7_sel}, 32'h20);
        dp    = 8'h00;
        blank = 8'h00;
        rst   = 1'b1;
        @(negedge clk);
        chk("mid_rst seg7_sel", {24'd0, seg7_sel}, 32'h0);
        chk("mid_rst seg7", {24'd0, seg7}, 32'h0);
        chk("mid_rst frame_start", {31'd0, frame_start}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst frame_start", {31'd0, frame_start}, 32'd1);
        exp_dig = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
        check_frame("restart", -1, 32'h0);

        // Leading zeros: blanked only when the optional feature is built in.
        digits = 32'h0000_0105;
        wait_fs();
`ifdef SEG7_LZB_EN
        exp_dig = '{8'h6D, 8'h3F, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        exp_dig = '{8'h6D, 8'h3F, 8'h06, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
        check_frame("lead_zero", -1, 32'h0);

        digits = 32'h0000_0000;
        wait_fs();
`ifdef SEG7_LZB_EN
        exp_dig = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        exp_dig = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
        check_frame("all_zero", -1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
